// File: rtl/race_initiator.sv
// Initiator side of the four-phase start/done handshake: runs a programmed
// number of races per go pulse, measuring response latency and flagging timeouts.
module race_initiator #(
  parameter int CNT_W   = 16,
  parameter int RACES_W = 8,
  parameter int TIMEOUT = 1000,
  parameter int GAP_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               go,
  input  logic [RACES_W-1:0] num_races,
  input  logic               done,
  output logic               start,
  output logic               busy,
  output logic               finished,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   last_lat,
  output logic [CNT_W-1:0]   max_lat,
  output logic [RACES_W-1:0] race_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GAP  = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_REL  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam int               GAP_W      = $clog2(GAP_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LIM    = GAP_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

  logic [2:0]         state_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic [CNT_W-1:0]   lat_cnt_reg;
  logic [RACES_W-1:0] num_reg;
  logic [RACES_W-1:0] races_reg;
  logic               aborted_reg;

  logic [CNT_W-1:0]   lat_next;
  logic [RACES_W-1:0] races_next;

  // Latency counts the edge that samples done as well, saturating at all-ones.
  assign lat_next   = (lat_cnt_reg == '1) ? '1 : lat_cnt_reg + 1'b1;
  // Completed plus aborted races, compared for equality against the latched count.
  assign races_next = races_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg   <= S_IDLE;
      gap_cnt_reg <= '0;
      lat_cnt_reg <= '0;
      num_reg     <= '0;
      races_reg   <= '0;
      aborted_reg <= 1'b0;
      start       <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      timeout_err <= 1'b0;
      last_lat    <= '0;
      max_lat     <= '0;
      race_count  <= '0;
    end else begin
      finished <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (go) begin
            busy <= 1'b1;
            if (num_races != '0) begin
              num_reg     <= num_races;
              races_reg   <= '0;
              race_count  <= '0;
              max_lat     <= '0;
              last_lat    <= '0;
              timeout_err <= 1'b0;
              gap_cnt_reg <= '0;
              state_reg   <= S_GAP;
            end else begin
              state_reg <= S_FIN;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt_reg >= GAP_LIM && !done) begin
            start       <= 1'b1;
            lat_cnt_reg <= '0;
            aborted_reg <= 1'b0;
            state_reg   <= S_REQ;
          end else if (gap_cnt_reg < GAP_LIM) begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end

        S_REQ: begin
          if (done) begin
            last_lat    <= lat_next;
            if (lat_next > max_lat) max_lat <= lat_next;
            start       <= 1'b0;
            lat_cnt_reg <= '0;
            state_reg   <= S_REL;
          end else if (lat_cnt_reg == TIMEOUT_M1) begin
            timeout_err <= 1'b1;
            aborted_reg <= 1'b1;
            start       <= 1'b0;
            lat_cnt_reg <= '0;
            state_reg   <= S_REL;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 1'b1;
          end
        end

        S_REL: begin
          if (!done) begin
            if (!aborted_reg) race_count <= race_count + 1'b1;
            races_reg <= races_next;
            if (races_next == num_reg) begin
              state_reg <= S_FIN;
            end else begin
              gap_cnt_reg <= '0;
              state_reg   <= S_GAP;
            end
          end else if (lat_cnt_reg == TIMEOUT_M1) begin
            // Responder stuck high: abandon the rest of the run.
            timeout_err <= 1'b1;
            state_reg   <= S_FIN;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 1'b1;
          end
        end

        S_FIN: begin
          finished  <= 1'b1;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          start     <= 1'b0;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
